// File: rtl/product_accumulator.sv
// Frame accumulator for the 3x3 multiplier's 6-bit products.
// Sums N accepted products, then holds the result until the consumer takes it.
module product_accumulator #(
  parameter int N     = 4,
  parameter int ACC_W = 8,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  input  logic [5:0]       in_p,
  output logic             in_ready,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [ACC_W-1:0] acc_out,
  output logic             overflow,
  output logic [CNT_W-1:0] count
);

  typedef enum logic {
    ACCUM = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t           state;
  logic [ACC_W:0]   sum_ext;
  logic             last_product;

  // One extra bit captures the carry that feeds the sticky overflow flag.
  always_comb begin
    sum_ext      = {1'b0, acc_out} + (ACC_W + 1)'(in_p);
    last_product = (count == CNT_W'(N - 1));
  end

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      state    <= ACCUM;
      acc_out  <= '0;
      overflow <= 1'b0;
      count    <= '0;
    end else begin
      case (state)
        ACCUM: begin
          if (in_valid) begin
            acc_out  <= sum_ext[ACC_W-1:0];
            overflow <= overflow | sum_ext[ACC_W];
            count    <= count + CNT_W'(1);
            if (last_product) state <= HOLD;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state    <= ACCUM;
            acc_out  <= '0;
            overflow <= 1'b0;
            count    <= '0;
          end
        end
        default: state <= ACCUM;
      endcase
    end
  end

  always_comb begin
    in_ready  = (state == ACCUM);
    out_valid = (state == HOLD);
  end

endmodule

// File: tb/tb_product_accumulator.sv
// Bench for product_accumulator: two instances (N=4 and N=6) share one stimulus
// stream and are compared every cycle against a frame-level sum model.
module tb_product_accumulator;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       in_valid;
  logic [5:0] in_p;
  logic       out_ready;

  logic       in_ready_o  [2];
  logic       out_valid_o [2];
  logic [7:0] acc_o       [2];
  logic       ovf_o       [2];
  logic [2:0] cnt_o       [2];

  int checks = 0;
  int errors = 0;

  product_accumulator #(.N(4), .ACC_W(8), .CNT_W(3)) u_n4 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_p(in_p),
    .in_ready(in_ready_o[0]), .out_ready(out_ready), .out_valid(out_valid_o[0]),
    .acc_out(acc_o[0]), .overflow(ovf_o[0]), .count(cnt_o[0])
  );

  product_accumulator #(.N(6), .ACC_W(8), .CNT_W(3)) u_n6 (
    .clk(clk), .rst(rst), .clear(clear), .in_valid(in_valid), .in_p(in_p),
    .in_ready(in_ready_o[1]), .out_ready(out_ready), .out_valid(out_valid_o[1]),
    .acc_out(acc_o[1]), .overflow(ovf_o[1]), .count(cnt_o[1])
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model: the full (unbounded) frame sum, products accepted, and whether a result is pending.
  int frame_n [2] = '{4, 6};
  int m_sum   [2];
  int m_cnt   [2];
  bit m_hold  [2];
  bit started = 1'b0;

  always @(posedge clk) begin
    for (int i = 0; i < 2; i++) begin
      int  s;
      int  c;
      bit  h;
      s = m_sum[i];
      c = m_cnt[i];
      h = m_hold[i];
      if (rst || clear) begin
        s = 0; c = 0; h = 1'b0;
      end else if (h) begin
        if (out_ready) begin
          s = 0; c = 0; h = 1'b0;
        end
      end else if (in_valid) begin
        s = s + int'(in_p);
        c = c + 1;
        if (c == frame_n[i]) h = 1'b1;
      end
      m_sum[i]  <= s;
      m_cnt[i]  <= c;
      m_hold[i] <= h;
    end
    if (rst) started <= 1'b1;
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (started) begin
      for (int i = 0; i < 2; i++) begin
        chk($sformatf("u%0d.in_ready", i), int'(in_ready_o[i]), int'(!m_hold[i]));
        chk($sformatf("u%0d.out_valid", i), int'(out_valid_o[i]), int'(m_hold[i]));
        chk($sformatf("u%0d.acc_out", i), int'(acc_o[i]), m_sum[i] % 256);
        chk($sformatf("u%0d.overflow", i), int'(ovf_o[i]), int'(m_sum[i] > 255));
        chk($sformatf("u%0d.count", i), int'(cnt_o[i]), m_cnt[i]);
      end
    end
  end

  // Drive one cycle's inputs, then return just after the edge that consumes them.
  task automatic step(input logic v, input logic [5:0] p, input logic ordy,
                      input logic clr, input logic r);
    @(negedge clk);
    #1;
    in_valid  = v;
    in_p      = p;
    out_ready = ordy;
    clear     = clr;
    rst       = r;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int vals [4];
    rst = 1'b1; clear = 1'b0; in_valid = 1'b0; in_p = '0; out_ready = 1'b0;

    step(0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 1);
    chk("rst_acc", int'(acc_o[0]), 0);
    chk("rst_count", int'(cnt_o[0]), 0);
    chk("rst_in_ready", int'(in_ready_o[0]), 1);
    chk("rst_out_valid", int'(out_valid_o[0]), 0);

    // Back-to-back full-scale frame
    for (int k = 0; k < 4; k++) begin
      if (k < 3) begin
        step(1, 49, 1, 0, 0);
        chk("b2b_in_ready", int'(in_ready_o[0]), 1);
      end else begin
        step(1, 49, 1, 0, 0);
      end
    end
    chk("b2b_out_valid", int'(out_valid_o[0]), 1);
    chk("b2b_acc", int'(acc_o[0]), 196);
    chk("b2b_ovf", int'(ovf_o[0]), 0);
    chk("b2b_count", int'(cnt_o[0]), 4);
    step(0, 0, 1, 0, 0);
    chk("b2b_drain_acc", int'(acc_o[0]), 0);
    chk("b2b_drain_count", int'(cnt_o[0]), 0);
    chk("b2b_drain_in_ready", int'(in_ready_o[0]), 1);
    step(0, 0, 0, 1, 0);

    // Bubbles between products
    vals = '{6, 0, 12, 35};
    for (int k = 0; k < 4; k++) begin
      step(1, 6'(vals[k]), 0, 0, 0);
      if (k < 3) begin
        chk("bubble_count", int'(cnt_o[0]), k + 1);
        step(0, 0, 0, 0, 0);
        step(0, 0, 0, 0, 0);
        chk("bubble_count_idle", int'(cnt_o[0]), k + 1);
      end
    end
    chk("bubble_acc", int'(acc_o[0]), 53);
    chk("bubble_ovf", int'(ovf_o[0]), 0);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);

    // Overflow on the N=6 instance
    for (int k = 0; k < 6; k++) step(1, 49, 1, 0, 0);
    chk("ovf_acc", int'(acc_o[1]), 38);
    chk("ovf_flag", int'(ovf_o[1]), 1);
    chk("ovf_out_valid", int'(out_valid_o[1]), 1);
    step(0, 0, 1, 0, 0);
    chk("ovf_cleared", int'(ovf_o[1]), 0);
    step(0, 0, 0, 1, 0);

    // Backpressure with in_valid asserted during HOLD
    for (int k = 1; k <= 4; k++) step(1, 6'(k), 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(1, 7, 0, 0, 0);
      chk("bp_acc", int'(acc_o[0]), 10);
      chk("bp_in_ready", int'(in_ready_o[0]), 0);
      chk("bp_out_valid", int'(out_valid_o[0]), 1);
    end
    step(0, 0, 1, 0, 0);
    chk("bp_after_out_valid", int'(out_valid_o[0]), 0);
    chk("bp_after_in_ready", int'(in_ready_o[0]), 1);
    step(0, 0, 0, 1, 0);

    // Mid-frame abort drops the product presented with clear
    step(1, 20, 0, 0, 0);
    step(1, 30, 0, 0, 0);
    step(1, 5, 0, 1, 0);
    chk("abort_acc", int'(acc_o[0]), 0);
    chk("abort_count", int'(cnt_o[0]), 0);
    for (int k = 0; k < 4; k++) step(1, 1, 0, 0, 0);
    chk("abort_next_acc", int'(acc_o[0]), 4);
    step(0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0);

    // Reset mid-frame and during HOLD
    step(1, 9, 0, 0, 0);
    step(1, 9, 0, 0, 0);
    step(1, 3, 0, 0, 1);
    chk("rst_mid_acc", int'(acc_o[0]), 0);
    chk("rst_mid_count", int'(cnt_o[0]), 0);
    for (int k = 0; k < 4; k++) step(1, 5, 0, 0, 0);
    chk("rst_hold_pre", int'(out_valid_o[0]), 1);
    step(0, 0, 0, 0, 1);
    chk("rst_hold_out_valid", int'(out_valid_o[0]), 0);
    chk("rst_hold_acc", int'(acc_o[0]), 0);
    for (int k = 0; k < 4; k++) step(1, 2, 0, 0, 0);
    chk("rst_next_acc", int'(acc_o[0]), 8);
    step(0, 0, 1, 0, 0);

    // Randomized traffic, including out-of-range products, clears and resets
    for (int k = 0; k < 3000; k++) begin
      step(($urandom % 4) != 0, 6'($urandom % 64), ($urandom % 3) != 0,
           ($urandom % 50) == 0, ($urandom % 97) == 0);
    end

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/product_accumulator.md
Name: product_accumulator

Overview:
- Downstream consumer of the 3x3 multiplier's 6-bit product.
- Accepts products through a valid/ready handshake and sums a frame of N products into a wider register.
- Presents the frame sum with a sticky overflow flag through a second valid/ready handshake.
- Forms the accumulate half of the lab's multiply-accumulate datapath.

Parameters:
- N, 4, number of products per frame; legal range 1 to 2^CNT_W-1.
- ACC_W, 8, accumulator and result width in bits; must be at least 6.
- CNT_W, 3, width of the frame counter and the count output.

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous frame abort; the current partial sum is discarded.
- in_valid  input  1  in_p holds a product this cycle.
- in_p  input  6  unsigned product, 0..49.
- in_ready  output  1  block accepts a product this cycle.
- out_ready  input  1  consumer accepts the result this cycle.
- out_valid  output  1  acc_out and overflow hold a completed frame result.
- acc_out  output  ACC_W  frame sum, modulo 2^ACC_W.
- overflow  output  1  the frame sum exceeded 2^ACC_W-1.
- count  output  CNT_W  products accepted so far in the current frame.

Behaviour:
- Reset (rst=1 at a clock edge):
  - state=ACCUM, acc_out=0, count=0, overflow=0, out_valid=0, in_ready=1.
  - rst has priority over every other input.
- Two states, ACCUM and HOLD:
  - in_ready = (state==ACCUM); out_valid = (state==HOLD). Both are decoded from the state register only.
  - in_ready never depends combinationally on in_valid or out_ready.
- Accept:
  - A product is accepted when in_valid & in_ready at a clock edge.
  - On accept: acc_out <= acc_out + zero-extended in_p, computed at ACC_W+1 bits.
  - The carry bit ORs into overflow (sticky for the frame); acc_out keeps the low ACC_W bits, wrapping.
  - On accept: count <= count+1.
- Frame end:
  - When the accepted product is the N-th (count==N-1 before the edge), the next state is HOLD and count becomes N.
  - out_valid rises the cycle after the N-th accept. Latency is 1 cycle from the final accept to result.
- HOLD:
  - acc_out, overflow and count are frozen. in_valid is ignored and nothing is accepted.
  - On out_valid & out_ready at an edge: next state is ACCUM; acc_out, count and overflow clear to 0.
  - in_ready rises the following cycle. There is no same-cycle result-drain-plus-accept.
- Idle cycles: in_valid=0 cycles in ACCUM leave all state unchanged. Input bubbles are legal anywhere in a frame.
- clear=1 at an edge (when rst=0):
  - Returns to ACCUM with acc_out=0, count=0, overflow=0, out_valid=0, in both states.
  - A product presented that cycle is dropped.
  - A pending HOLD result is discarded, even if out_ready=1.
- N=1: every accept goes directly to HOLD.
- in_p values above 49 are not expected from the multiplier, but are still summed as plain 6-bit unsigned.
- Outputs are registered or decoded from state only. There is no combinational path from in_p to any output.

Test Plan:
- Reset, then N=4, ACC_W=8, send 49,49,49,49 back-to-back with out_ready=1:
  - in_ready stays 1 for 4 cycles; out_valid is 1 on the following cycle.
  - acc_out=196, overflow=0, count=4, then everything clears to 0 the next cycle.
- Bubbles, N=4: send products 6,0,12,35 with in_valid low for 2 cycles between each -> acc_out=53, overflow=0, count increments only on accepts.
- Overflow, N=6, ACC_W=8: send six 49s -> acc_out=38 (294 mod 256), overflow=1; overflow returns to 0 after the handshake.
- Backpressure, N=4: products 1,2,3,4 with out_ready=0 for 5 cycles:
  - out_valid=1 and acc_out=10 held constant; in_ready=0.
  - in_valid=1 with in_p=7 during HOLD does not change acc_out.
  - Raise out_ready -> one transfer, then in_ready=1.
- Mid-frame abort: accept 20 and 30, pulse clear together with in_valid=1, in_p=5:
  - acc_out=0, count=0 next cycle.
  - Then 1,1,1,1 -> acc_out=4.
- Reset mid-frame and in HOLD: assert rst after 2 accepts, and again during HOLD with out_ready=0 -> all outputs at reset values the next cycle; the next frame 2,2,2,2 yields acc_out=8.
